// File: rtl/wb_timer_pkg.sv
// rtl/wb_timer_pkg.sv - shared constants and helpers for the wishbone timer
package wb_timer_pkg;

    localparam logic [31:0] ID_VALUE_DEFAULT = 32'h5754_4D52;
    localparam logic [31:0] COMPARE_RESET    = 32'hFFFF_FFFF;

    localparam logic [11:0] ADDR_CTRL     = 12'h000;
    localparam logic [11:0] ADDR_PRESCALE = 12'h004;
    localparam logic [11:0] ADDR_COMPARE  = 12'h008;
    localparam logic [11:0] ADDR_STATUS   = 12'h00C;
    localparam logic [11:0] ADDR_COUNT    = 12'h100;
    localparam logic [11:0] ADDR_ID       = 12'h104;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_ONESHOT = 1;
    localparam int CTRL_IRQ_EN  = 2;
    localparam int CTRL_CLR     = 8;

    typedef enum logic [2:0] {
        REG_CTRL,
        REG_PRESCALE,
        REG_COMPARE,
        REG_STATUS,
        REG_COUNT,
        REG_ID,
        REG_NONE
    } reg_sel_e;

    // Byte lanes are decoded on the word address only.
    function automatic reg_sel_e decode(input logic [11:0] adr);
        case (adr[11:2])
            ADDR_CTRL[11:2]:     return REG_CTRL;
            ADDR_PRESCALE[11:2]: return REG_PRESCALE;
            ADDR_COMPARE[11:2]:  return REG_COMPARE;
            ADDR_STATUS[11:2]:   return REG_STATUS;
            ADDR_COUNT[11:2]:    return REG_COUNT;
            ADDR_ID[11:2]:       return REG_ID;
            default:             return REG_NONE;
        endcase
    endfunction

    function automatic logic [31:0] byte_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/wb_timer_presc.sv
// rtl/wb_timer_presc.sv - free-running prescaler emitting one tick per limit+1 enabled cycles
module wb_timer_presc
    import wb_timer_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        clr,
    input  logic [15:0] limit,
    output logic        tick
);

    logic [15:0] cnt;

    assign tick = en & (cnt == limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? 16'd0 : cnt + 16'd1;
        end
    end

endmodule

// File: rtl/wb_timer.sv
// rtl/wb_timer.sv - wishbone slave timer with prescaler, compare match and interrupt
module wb_timer
    import wb_timer_pkg::*;
#(
    parameter logic [31:0] ID_VALUE = ID_VALUE_DEFAULT
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic [11:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic        wb_ack_o,
    output logic        irq_o
);

    logic        ready;
    logic        access;
    logic        wr;
    logic        tick;
    logic        clr;
    logic        match_hit;
    logic        ctrl_en;
    logic        ctrl_oneshot;
    logic        ctrl_irq_en;
    logic        match;
    logic [15:0] prescale;
    logic [31:0] compare;
    logic [31:0] count;
    logic [31:0] mask;
    logic [31:0] rdata;
    reg_sel_e    rsel;

    // Accesses are held off for one edge after reset release.
    assign access    = ready & wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wr        = access & wb_we_i;
    assign rsel      = decode(wb_adr_i);
    assign mask      = byte_mask(wb_sel_i);
    assign clr       = wr & (rsel == REG_CTRL) & mask[CTRL_CLR] & wb_dat_i[CTRL_CLR];
    assign match_hit = tick & ~clr & (count == compare);
    assign irq_o     = match & ctrl_irq_en;

    wb_timer_presc u_presc (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_n_i),
        .en    (ctrl_en),
        .clr   (clr),
        .limit (prescale),
        .tick  (tick)
    );

    always_comb begin
        rdata = '0;
        case (rsel)
            REG_CTRL:     rdata = {29'b0, ctrl_irq_en, ctrl_oneshot, ctrl_en};
            REG_PRESCALE: rdata = {16'b0, prescale};
            REG_COMPARE:  rdata = compare;
            REG_STATUS:   rdata = {31'b0, match};
            REG_COUNT:    rdata = count;
            REG_ID:       rdata = ID_VALUE;
            default:      rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            ready    <= 1'b0;
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            ready    <= 1'b1;
            wb_ack_o <= access;
            wb_dat_o <= (access & ~wb_we_i) ? rdata : 32'h0;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            ctrl_en      <= 1'b0;
            ctrl_oneshot <= 1'b0;
            ctrl_irq_en  <= 1'b0;
            prescale     <= '0;
            compare      <= COMPARE_RESET;
            match        <= 1'b0;
            count        <= '0;
        end else begin
            if (match_hit && ctrl_oneshot) ctrl_en <= 1'b0;
            // A bus write to CTRL overrides the one-shot auto-disable on the same edge.
            if (wr && rsel == REG_CTRL) begin
                if (mask[CTRL_EN])      ctrl_en      <= wb_dat_i[CTRL_EN];
                if (mask[CTRL_ONESHOT]) ctrl_oneshot <= wb_dat_i[CTRL_ONESHOT];
                if (mask[CTRL_IRQ_EN])  ctrl_irq_en  <= wb_dat_i[CTRL_IRQ_EN];
            end
            if (wr && rsel == REG_PRESCALE)
                prescale <= (prescale & ~mask[15:0]) | (wb_dat_i[15:0] & mask[15:0]);
            if (wr && rsel == REG_COMPARE)
                compare <= (compare & ~mask) | (wb_dat_i & mask);
            match <= match_hit |
                     (match & ~(wr && rsel == REG_STATUS && mask[0] && wb_dat_i[0]));
            if (clr)
                count <= '0;
            else if (tick)
                count <= (count == compare) ? 32'h0 : count + 32'h1;
        end
    end

endmodule

// File: doc/wb_timer.md
WB_TIMER -- requirements
Module: wb_timer

Interface
REQ-001 Parameter: ID_VALUE, default 32'h5754_4D52, constant returned by the ID register.
REQ-002 wb_clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 wb_rst_n_i  input  1  asynchronous, active-low reset.
REQ-004 wb_adr_i  input  12  byte address; bits [1:0] ignored.
REQ-005 wb_dat_i  input  32  write data.
REQ-006 wb_dat_o  output  32  read data, valid while wb_ack_o is high.
REQ-007 wb_we_i  input  1  high means write.
REQ-008 wb_sel_i  input  4  byte enables for writes; sel[n] gates bits [8n+7:8n].
REQ-009 wb_stb_i  input  1  strobe.
REQ-010 wb_cyc_i  input  1  cycle valid.
REQ-011 wb_ack_o  output  1  single-cycle acknowledge.
REQ-012 irq_o  output  1  level interrupt, high when STATUS.MATCH=1 and CTRL.IRQ_EN=1.

Function
REQ-013 Bus handshake: wb_ack_o shall rise one cycle after a cycle with wb_cyc_i=1, wb_stb_i=1 and wb_ack_o=0, and shall be high for exactly one cycle.
REQ-014 A strobe held over several cycles shall produce ack pulses on alternate cycles, one access per pulse.
REQ-015 Register writes take effect on the same edge that raises wb_ack_o. Read data is registered on that edge from the pre-edge register values.
REQ-016 Register map:
  - 0x000 CTRL RW: [0] EN, [1] ONESHOT, [2] IRQ_EN; [8] CLR is write-1 and self-clearing, and always reads 0.
  - 0x004 PRESCALE RW [15:0]; upper bits read 0.
  - 0x008 COMPARE RW [31:0].
  - 0x00C STATUS: [0] MATCH, sticky, write-1-to-clear.
  - 0x100 COUNT RO.
  - 0x104 ID RO, value ID_VALUE.
REQ-017 Unmapped addresses and writes to RO registers shall still be acked. Such writes shall be ignored, and reads shall return 0.
REQ-018 Prescaler: a 16-bit counter shall run while EN=1. When it equals PRESCALE it shall emit a one-cycle tick and return to 0; otherwise it increments by 1. PRESCALE=0 therefore gives a tick every cycle.
REQ-019 On a tick with COUNT==COMPARE: MATCH<=1 and COUNT<=0. If ONESHOT=1, EN<=0 on the same edge.
REQ-020 On a tick with COUNT!=COMPARE: COUNT<=COUNT+1, modulo 2^32 (0xFFFF_FFFF wraps to 0, and MATCH is not set).
REQ-021 While EN=0, COUNT and the prescaler shall hold.
REQ-022 CLR write: COUNT<=0 and prescaler<=0. CLR wins over a simultaneous tick. EN is updated from the same write data.
REQ-023 STATUS W1C and a MATCH set in the same cycle: set wins.
REQ-024 A COMPARE write coincident with a tick: that tick's comparison shall use the old COMPARE.
REQ-025 A bus write clearing EN coincident with a tick: that tick is still processed.

Reset
REQ-026 Asserting wb_rst_n_i=0 shall asynchronously force all of the following to 0: CTRL, PRESCALE, STATUS, COUNT, prescaler counter, wb_ack_o, wb_dat_o, irq_o. COMPARE resets to 32'hFFFF_FFFF.
REQ-027 Reset asserted mid-access shall abort that access: no ack, no register update.
REQ-028 Release of reset shall be taken synchronously. The first ack is possible no earlier than the second edge after release.

Structure
REQ-029 Shared package wb_timer_pkg shall hold: register address constants, CTRL bit positions, default ID_VALUE, and the COMPARE reset value.
REQ-030 The prescaler shall be a sub-module, wb_timer_presc, with inputs clk, rst_n, en, clr and limit[15:0], and output tick.
REQ-031 RTL shall be 120-400 lines and contain no latches.

Verification
REQ-032 Read 0x104 after reset: ack 1 cycle after stb, data=ID_VALUE. Read 0x100: data=0. Read 0x008: data=FFFF_FFFF.
REQ-033 Write PRESCALE=3, COMPARE=5, CTRL=0x5 (EN, IRQ_EN):
  - COUNT increments every 4 cycles.
  - After 24 cycles of enable, MATCH=1, irq_o=1 and COUNT=0.
  - Counting continues.
REQ-034 Same setup with CTRL=0x3 (EN, ONESHOT): after the match, EN reads 0 and COUNT stays 0 for 100 cycles.
REQ-035 Write STATUS=1 in the same cycle as a match tick: MATCH remains 1. Write STATUS=1 on a later cycle: MATCH=0 and irq_o=0.
REQ-036 Write CTRL with sel=4'b0000: CTRL unchanged, ack still returned. Write to 0x100 and 0x200: ack returned, COUNT unaffected, a read of 0x200 returns 0.
REQ-037 Assert reset while stb is pending before ack: no ack; all registers at reset values; a subsequent read of 0x000 returns 0.
